// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register with redirect/stall handling, IF/ID
// pipeline register with bubble injection, and a saturating redirect counter.
module fetch_stage #(
    parameter int unsigned          XLEN      = 32,
    parameter logic [XLEN-1:0]      RESET_PC  = '0,
    parameter logic [31:0]          NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc_f,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic [15:0]     redirect_count
);

    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] pc_plus4_f;
    logic [31:0]     instr_q, instr_nx;
    logic [XLEN-1:0] pcid_q, pcid_nx;
    logic [XLEN-1:0] pc4id_q, pc4id_nx;
    logic            valid_q, valid_nx;
    logic [15:0]     cnt_q, cnt_d;

    // Wraps modulo 2^XLEN by construction.
    assign pc_plus4_f = pcf_q + XLEN'(4);

    // Redirect beats a fetch stall; target is forced word-aligned.
    always_comb begin
        pcf_d = pc_plus4_f;
        if (pc_src_e)
            pcf_d = {pc_target_e[XLEN-1:2], 2'b00};
        else if (stall_f)
            pcf_d = pcf_q;
    end

    // Flush beats a decode stall so a bubble is always inserted.
    always_comb begin
        instr_nx = instr_q;
        pcid_nx  = pcid_q;
        pc4id_nx = pc4id_q;
        valid_nx = valid_q;
        if (flush_d) begin
            instr_nx = NOP_INSTR;
            pcid_nx  = '0;
            pc4id_nx = '0;
            valid_nx = 1'b0;
        end else if (!stall_d) begin
            instr_nx = imem_rdata;
            pcid_nx  = pcf_q;
            pc4id_nx = pc_plus4_f;
            valid_nx = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (pc_src_e && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_q   <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcid_q  <= '0;
            pc4id_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pcf_q   <= pcf_d;
            instr_q <= instr_nx;
            pcid_q  <= pcid_nx;
            pc4id_q <= pc4id_nx;
            valid_q <= valid_nx;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_f           = pcf_q;
    assign imem_addr      = pcf_q;
    assign instr_d        = instr_q;
    assign pc_d           = pcid_q;
    assign pc_plus4_d     = pc4id_q;
    assign valid_d        = valid_q;
    assign redirect_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns 0xA0 + address.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, pc_src_e, stall_f, stall_d, flush_d;
    logic [31:0] pc_target_e, imem_addr, imem_rdata, pc_f, instr_d, pc_d, pc_plus4_d;
    logic        valid_d;
    logic [15:0] redirect_count;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'hA0 + imem_addr;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc_f(pc_f),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .valid_d(valid_d), .redirect_count(redirect_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1; pc_src_e = 0; pc_target_e = 0; stall_f = 0; stall_d = 0; flush_d = 0;
        tick; tick;
        checks++; if (pc_f !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h/%h exp 0", pc_f, imem_addr); end
        checks++; if (instr_d !== NOP || valid_d !== 1'b0) begin errors++; $display("FAIL reset_ifid: got %h v%b exp %h v0", instr_d, valid_d, NOP); end
        checks++; if (pc_d !== 0 || pc_plus4_d !== 0 || redirect_count !== 0) begin errors++; $display("FAIL reset_misc: got %h %h %h exp 0 0 0", pc_d, pc_plus4_d, redirect_count); end
        reset = 0;
    endtask

    task automatic test_sequential;
        logic [31:0] exp_pc [2];
        logic [31:0] exp_in [2];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8;
        exp_in[0] = 32'hA0; exp_in[1] = 32'hA4;
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++; if (pc_f !== exp_pc[i]) begin errors++; $display("FAIL seq_pc%0d: got %h exp %h", i, pc_f, exp_pc[i]); end
            checks++; if (instr_d !== exp_in[i] || valid_d !== 1'b1) begin errors++; $display("FAIL seq_instr%0d: got %h v%b exp %h v1", i, instr_d, valid_d, exp_in[i]); end
            checks++; if (pc_d !== exp_pc[i] - 4 || pc_plus4_d !== exp_pc[i]) begin errors++; $display("FAIL seq_pcd%0d: got %h/%h exp %h/%h", i, pc_d, pc_plus4_d, exp_pc[i] - 4, exp_pc[i]); end
        end
    endtask

    task automatic test_branch;
        tick; tick;
        checks++; if (pc_f !== 32'h10) begin errors++; $display("FAIL br_setup: got %h exp 10", pc_f); end
        pc_src_e = 1; pc_target_e = 32'h40; flush_d = 1;
        tick;
        pc_src_e = 0; flush_d = 0;
        checks++; if (pc_f !== 32'h40) begin errors++; $display("FAIL br_pc: got %h exp 40", pc_f); end
        checks++; if (valid_d !== 1'b0 || instr_d !== NOP) begin errors++; $display("FAIL br_bubble: got %h v%b exp %h v0", instr_d, valid_d, NOP); end
        checks++; if (redirect_count !== 16'd1) begin errors++; $display("FAIL br_count: got %0d exp 1", redirect_count); end
        tick;
        checks++; if (instr_d !== 32'hE0 || pc_d !== 32'h40 || valid_d !== 1'b1 || pc_f !== 32'h44) begin errors++; $display("FAIL br_target: got %h %h v%b pc %h exp e0 40 v1 pc 44", instr_d, pc_d, valid_d, pc_f); end
    endtask

    task automatic test_stall;
        pc_src_e = 1; pc_target_e = 32'h1C; flush_d = 1;
        tick;
        pc_src_e = 0; flush_d = 0;
        tick;
        checks++; if (pc_f !== 32'h20 || instr_d !== 32'hBC || pc_d !== 32'h1C) begin errors++; $display("FAIL st_setup: got %h %h %h exp 20 bc 1c", pc_f, instr_d, pc_d); end
        stall_f = 1; stall_d = 1;
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++; if (pc_f !== 32'h20 || instr_d !== 32'hBC || pc_d !== 32'h1C || valid_d !== 1'b1) begin errors++; $display("FAIL st_hold%0d: got %h %h %h v%b exp 20 bc 1c v1", i, pc_f, instr_d, pc_d, valid_d); end
        end
        stall_f = 0; stall_d = 0;
        tick;
        checks++; if (pc_f !== 32'h24 || pc_d !== 32'h20 || instr_d !== 32'hC0) begin errors++; $display("FAIL st_resume: got %h %h %h exp 24 20 c0", pc_f, pc_d, instr_d); end
    endtask

    task automatic test_priority;
        pc_src_e = 1; pc_target_e = 32'h83; stall_f = 1; flush_d = 1; stall_d = 1;
        tick;
        pc_src_e = 0; stall_f = 0; flush_d = 0; stall_d = 0;
        checks++; if (pc_f !== 32'h80) begin errors++; $display("FAIL pri_pc: got %h exp 80", pc_f); end
        checks++; if (instr_d !== NOP || valid_d !== 1'b0 || pc_d !== 0 || pc_plus4_d !== 0) begin errors++; $display("FAIL pri_bubble: got %h v%b %h %h exp %h v0 0 0", instr_d, valid_d, pc_d, pc_plus4_d, NOP); end
        checks++; if (redirect_count !== 16'd3) begin errors++; $display("FAIL pri_count: got %0d exp 3", redirect_count); end
        tick;
        checks++; if (pc_f !== 32'h84 || pc_d !== 32'h80) begin errors++; $display("FAIL pri_next: got %h %h exp 84 80", pc_f, pc_d); end
    endtask

    task automatic test_wrap;
        pc_src_e = 1; pc_target_e = 32'hFFFF_FFFC; flush_d = 1;
        tick;
        pc_src_e = 0; flush_d = 0;
        checks++; if (pc_f !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got %h exp fffffffc", pc_f); end
        tick;
        checks++; if (pc_f !== 32'h0 || pc_plus4_d !== 32'h0 || pc_d !== 32'hFFFF_FFFC || instr_d !== 32'h9C) begin errors++; $display("FAIL wrap: got %h %h %h %h exp 0 0 fffffffc 9c", pc_f, pc_plus4_d, pc_d, instr_d); end
    endtask

    task automatic test_saturation;
        checks++; if (redirect_count !== 16'd4) begin errors++; $display("FAIL sat_start: got %0d exp 4", redirect_count); end
        pc_src_e = 1; pc_target_e = 32'h30; flush_d = 1;
        repeat (70000) tick;
        checks++; if (redirect_count !== 16'hFFFF) begin errors++; $display("FAIL sat: got %h exp ffff", redirect_count); end
        checks++; if (pc_f !== 32'h30) begin errors++; $display("FAIL sat_pc: got %h exp 30", pc_f); end
    endtask

    task automatic test_reset_mid_stall;
        stall_f = 1; stall_d = 1; reset = 1;
        tick;
        reset = 0; pc_src_e = 0; flush_d = 0; stall_f = 0; stall_d = 0;
        checks++; if (pc_f !== 32'h0 || instr_d !== NOP || valid_d !== 1'b0) begin errors++; $display("FAIL rst_mid: got %h %h v%b exp 0 %h v0", pc_f, instr_d, valid_d, NOP); end
        checks++; if (redirect_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", redirect_count); end
        tick;
        checks++; if (pc_f !== 32'h4 || instr_d !== 32'hA0) begin errors++; $display("FAIL rst_restart: got %h %h exp 4 a0", pc_f, instr_d); end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_branch;
        test_stall;
        test_priority;
        test_wrap;
        test_saturation;
        test_reset_mid_stall;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
